// File: rtl/ialign_buffer.sv
// Halfword-granular instruction fetch queue: prefetches aligned words and realigns 16/32-bit instructions for decode.
// Define IALIGN_BYPASS_EN to let an accepted response reach instr_o in the same cycle when the queue cannot supply it.
module ialign_buffer #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush_i,
    input  logic [31:0] jump_pc_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic        compressed_o,
    output logic [31:0] pc_o
);

    localparam int unsigned HW = 2 * DEPTH;
    localparam int unsigned PW = $clog2(HW);
    localparam int unsigned CW = PW + 2;

    typedef logic [CW-1:0] cnt_t;

    logic [15:0]   r_q [HW];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    cnt_t          r_hw_cnt;
    cnt_t          r_out;
    cnt_t          r_discard;
    logic [31:0]   r_fpc;
    logic [31:0]   r_pc;
    logic          r_skip_lo;

    logic [PW-1:0] w_head1;
    logic [PW-1:0] w_tail1;
    logic [CW:0]   w_need;
    logic          w_req;
    logic          w_accept;
    logic [1:0]    w_push_n;
    logic [15:0]   w_push_lo;
    logic [15:0]   w_push_hi;
    logic [15:0]   w_h0;
    logic [15:0]   w_h1;
    cnt_t          w_avail;
    logic          w_is_c;
    logic          w_valid;
    logic          w_pop;
    logic [1:0]    w_pop_cnt;
    logic [1:0]    w_byp_used;
    logic          w_wr_lo;
    logic          w_wr_hi;
    logic          w_unused;

    assign w_unused = jump_pc_i[0];

    assign w_head1 = r_head + PW'(1);
    assign w_tail1 = r_tail + PW'(1);

    // Reserve room for every word already in flight plus the one being requested.
    assign w_need = {1'b0, r_hw_cnt} + {r_out, 1'b0} + (CW+1)'(2);
    assign w_req  = reset_n && !flush_i && (w_need <= (CW+1)'(HW));

    assign mem_req_o  = w_req;
    assign mem_addr_o = r_fpc;

    assign w_accept  = mem_rvalid_i && !flush_i && (r_discard == '0);
    assign w_push_lo = r_skip_lo ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    assign w_push_hi = mem_rdata_i[31:16];
    assign w_push_n  = !w_accept ? 2'd0 : (r_skip_lo ? 2'd1 : 2'd2);

`ifdef IALIGN_BYPASS_EN
    // Halfwords missing from the queue are taken from the incoming word, in arrival order.
    assign w_h0    = (r_hw_cnt != '0) ? r_q[r_head] : w_push_lo;
    assign w_h1    = (r_hw_cnt >= cnt_t'(2)) ? r_q[w_head1] :
                     ((r_hw_cnt == cnt_t'(1)) ? w_push_lo : w_push_hi);
    assign w_avail = r_hw_cnt + cnt_t'(w_push_n);
`else
    assign w_h0    = r_q[r_head];
    assign w_h1    = r_q[w_head1];
    assign w_avail = r_hw_cnt;
`endif

    assign w_is_c    = (w_h0[1:0] != 2'b11);
    assign w_valid   = ((w_avail >= cnt_t'(1)) && w_is_c) || (w_avail >= cnt_t'(2));
    assign w_pop     = w_valid && instr_ready_i && !flush_i;
    assign w_pop_cnt = !w_pop ? 2'd0 : (w_is_c ? 2'd1 : 2'd2);

`ifdef IALIGN_BYPASS_EN
    always_comb begin
        w_byp_used = 2'd0;
        if (w_pop) begin
            if (r_hw_cnt == '0) begin
                w_byp_used = w_pop_cnt;
            end else if ((r_hw_cnt == cnt_t'(1)) && (w_pop_cnt == 2'd2)) begin
                w_byp_used = 2'd1;
            end
        end
    end
`else
    assign w_byp_used = 2'd0;
`endif

    assign w_wr_lo = (w_push_n != 2'd0) && (w_byp_used == 2'd0);
    assign w_wr_hi = (w_push_n == 2'd2) && (w_byp_used != 2'd2);

    assign instr_valid_o = w_valid;
    assign compressed_o  = w_valid && w_is_c;
    assign instr_o       = !w_valid ? 32'h0 : (w_is_c ? {16'h0, w_h0} : {w_h1, w_h0});
    assign pc_o          = r_pc;

    always_ff @(posedge clk) begin
        if (w_wr_lo) begin
            r_q[r_tail] <= w_push_lo;
        end
        if (w_wr_hi) begin
            r_q[w_tail1] <= w_push_hi;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_hw_cnt  <= '0;
            r_out     <= '0;
            r_discard <= '0;
            r_fpc     <= {BOOT_ADDR[31:2], 2'b00};
            r_pc      <= {BOOT_ADDR[31:1], 1'b0};
            r_skip_lo <= BOOT_ADDR[1];
        end else begin
            r_out <= r_out + cnt_t'(w_req) - cnt_t'(mem_rvalid_i);
            if (flush_i) begin
                // A response arriving with the flush is dropped here, so it is not counted as stale.
                r_head    <= '0;
                r_tail    <= '0;
                r_hw_cnt  <= '0;
                r_discard <= r_out - cnt_t'(mem_rvalid_i);
                r_fpc     <= {jump_pc_i[31:2], 2'b00};
                r_pc      <= {jump_pc_i[31:1], 1'b0};
                r_skip_lo <= jump_pc_i[1];
            end else begin
                if (w_req) begin
                    r_fpc <= r_fpc + 32'd4;
                end
                if (mem_rvalid_i && (r_discard != '0)) begin
                    r_discard <= r_discard - cnt_t'(1);
                end
                if (w_accept) begin
                    r_skip_lo <= 1'b0;
                end
                r_hw_cnt <= r_hw_cnt + cnt_t'(w_push_n) - cnt_t'(w_pop_cnt);
                r_head   <= r_head + PW'(w_pop_cnt);
                r_tail   <= r_tail + PW'(w_push_n);
                if (w_pop) begin
                    r_pc <= r_pc + {29'b0, w_pop_cnt, 1'b0};
                end
            end
        end
    end

    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!reset_n)
        mem_rvalid_i |-> (r_out != '0));

endmodule

// File: tb/tb_ialign_buffer.sv
// Scoreboard bench for ialign_buffer: directed fetch streams against a latency-configurable memory model.
module tb_ialign_buffer;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] BOOT  = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush_i;
    logic [31:0] jump_pc_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic        compressed_o;
    logic [31:0] pc_o;

    always #5 clk = ~clk;

    ialign_buffer #(.DEPTH(DEPTH), .BOOT_ADDR(BOOT)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .flush_i       (flush_i),
        .jump_pc_i     (jump_pc_i),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .compressed_o  (compressed_o),
        .pc_o          (pc_o)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        c;
    } exp_t;

    typedef struct packed {
        logic [31:0] addr;
        int unsigned due;
    } req_t;

    exp_t        exp_q[$];
    req_t        pend_q[$];
    logic [31:0] mem_words [logic [31:0]];
    int          checks   = 0;
    int          failures = 0;
    int unsigned lat      = 1;
    int unsigned cyc      = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_words.exists(a)) return mem_words[a];
        return 32'h00A0_0093;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    task automatic expect_i(input logic [31:0] instr, input logic [31:0] pc, input logic c);
        exp_q.push_back('{instr: instr, pc: pc, c: c});
    endtask

    // Memory: a request seen in cycle c is answered in cycle c+lat, in order.
    initial begin
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;
        forever begin
            @(negedge clk);
            if (reset_n && mem_req_o) pend_q.push_back('{addr: mem_addr_o, due: cyc + lat});
            @(posedge clk);
            #1;
            cyc++;
            if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = mem_word(pend_q[0].addr);
                void'(pend_q.pop_front());
            end else begin
                mem_rvalid_i = 1'b0;
                mem_rdata_i  = 32'h0;
            end
        end
    end

    // Monitor: every handshake that will complete at the next edge is compared against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && !flush_i && instr_valid_o && instr_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_instr: actual %h at pc %h required none", instr_o, pc_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("instr", instr_o, e.instr);
                    chk("pc", pc_o, e.pc);
                    chk("compressed", 32'(compressed_o), 32'(e.c));
                end
            end
        end
    end

    task automatic do_flush(input logic [31:0] tgt, input logic rdy);
        @(posedge clk);
        #1;
        flush_i   = 1'b1;
        jump_pc_i = tgt;
        @(negedge clk);
        chk("flush_no_req", 32'(mem_req_o), 32'd0);
        @(posedge clk);
        #1;
        flush_i       = 1'b0;
        instr_ready_i = rdy;
        @(negedge clk);
        chk("restart_req", 32'(mem_req_o), 32'd1);
        chk("restart_addr", mem_addr_o, {tgt[31:2], 2'b00});
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (exp_q.size() != 0 && n < 300);
        #1;
        instr_ready_i = 1'b0;
        chk(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n       = 1'b0;
        flush_i       = 1'b0;
        jump_pc_i     = 32'h0;
        instr_ready_i = 1'b0;
        mem_words[32'h0000_0000] = 32'h4501_4505;
        mem_words[32'h0000_0004] = 32'h0000_0513;
        mem_words[32'h0000_0200] = 32'h0093_4501;
        mem_words[32'h0000_0204] = 32'h1234_00A0;
        mem_words[32'h0000_0380] = 32'h1111_1111;
        mem_words[32'h0000_0384] = 32'h1111_1111;
        mem_words[32'h0000_0400] = 32'h0050_0113;
        mem_words[32'h0000_0600] = 32'hFFFF_4505;

        repeat (3) @(negedge clk);
        chk("rst_req", 32'(mem_req_o), 32'd0);
        chk("rst_addr", mem_addr_o, 32'h0000_0100);
        chk("rst_valid", 32'(instr_valid_o), 32'd0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_compressed", 32'(compressed_o), 32'd0);
        chk("rst_pc", pc_o, 32'h0000_0100);

        // Boot stream of identical 32-bit words.
        expect_i(32'h00A0_0093, 32'h100, 1'b0);
        expect_i(32'h00A0_0093, 32'h104, 1'b0);
        expect_i(32'h00A0_0093, 32'h108, 1'b0);
        @(posedge clk);
        #1;
        reset_n       = 1'b1;
        instr_ready_i = 1'b1;
        @(negedge clk);
        chk("boot_req0", 32'(mem_req_o), 32'd1);
        chk("boot_addr0", mem_addr_o, 32'h0000_0100);
        @(negedge clk);
        chk("boot_req1", 32'(mem_req_o), 32'd1);
        chk("boot_addr1", mem_addr_o, 32'h0000_0104);
        drain("boot_drain");

        // Two compressed instructions packed in one word.
        expect_i(32'h0000_4505, 32'h0, 1'b1);
        expect_i(32'h0000_4501, 32'h2, 1'b1);
        expect_i(32'h0000_0513, 32'h4, 1'b0);
        do_flush(32'h0000_0000, 1'b1);
        drain("compressed_drain");

        // Jump into an upper halfword; the 32-bit instruction straddles two words.
        expect_i(32'h00A0_0093, 32'h202, 1'b0);
        expect_i(32'h0000_1234, 32'h206, 1'b1);
        expect_i(32'h00A0_0093, 32'h208, 1'b0);
        do_flush(32'h0000_0202, 1'b1);
        @(negedge clk);
        chk("straddle_wait", 32'(instr_valid_o), 32'd0);
        drain("straddle_drain");

        // Decode stalled: queue fills to DEPTH words and the head holds still.
        do_flush(32'h0000_0300, 1'b0);
        repeat (15) @(negedge clk);
        chk("full_req", 32'(mem_req_o), 32'd0);
        chk("full_valid", 32'(instr_valid_o), 32'd1);
        chk("full_instr", instr_o, 32'h00A0_0093);
        chk("full_pc", pc_o, 32'h0000_0300);
        repeat (3) @(negedge clk);
        chk("stable_instr", instr_o, 32'h00A0_0093);
        chk("stable_pc", pc_o, 32'h0000_0300);
        chk("stable_compressed", 32'(compressed_o), 32'd0);
        expect_i(32'h00A0_0093, 32'h300, 1'b0);
        @(posedge clk);
        #1;
        instr_ready_i = 1'b1;
        @(negedge clk);
        chk("full_req_pop_cycle", 32'(mem_req_o), 32'd0);
        @(posedge clk);
        #1;
        instr_ready_i = 1'b0;
        @(negedge clk);
        chk("refill_req", 32'(mem_req_o), 32'd1);
        chk("refill_addr", mem_addr_o, 32'h0000_0310);
        chk("refill_pc", pc_o, 32'h0000_0304);
        chk("stall_pop_seen", 32'(exp_q.size()), 32'd0);

        // Flush with two responses in flight on a 3-cycle memory.
        @(posedge clk);
        #1;
        lat = 3;
        do_flush(32'h0000_0380, 1'b0);
        @(posedge clk);
        expect_i(32'h0050_0113, 32'h400, 1'b0);
        expect_i(32'h00A0_0093, 32'h404, 1'b0);
        do_flush(32'h0000_0400, 1'b1);
        drain("stale_drain");

        // Flush coinciding with a handshake and an arriving response.
        lat = 1;
        for (int k = 0; k < 20; k++) expect_i(32'h00A0_0093, 32'h500 + 32'(4 * k), 1'b0);
        do_flush(32'h0000_0500, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        flush_i   = 1'b1;
        jump_pc_i = 32'h0000_0600;
        exp_q.delete();
        expect_i(32'h0000_4505, 32'h600, 1'b1);
        expect_i(32'h0093_FFFF, 32'h602, 1'b0);
        expect_i(32'h0000_00A0, 32'h606, 1'b1);
        expect_i(32'h00A0_0093, 32'h608, 1'b0);
        @(negedge clk);
        chk("flushpop_valid", 32'(instr_valid_o), 32'd1);
        chk("flushpop_rvalid", 32'(mem_rvalid_i), 32'd1);
        chk("flushpop_no_req", 32'(mem_req_o), 32'd0);
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        @(negedge clk);
        chk("flushpop_empty", 32'(instr_valid_o), 32'd0);
        chk("flushpop_req", 32'(mem_req_o), 32'd1);
        chk("flushpop_addr", mem_addr_o, 32'h0000_0600);
        drain("flushpop_drain");

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
